// File: rtl/axi_write_master.sv
// AXI4 write-channel initiator: one burst command at a time, AW then registered W stage
// with internally generated wlast, then B collection reported on a one-cycle done pulse.
module axi_write_master #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int STROBE_WIDTH = DATA_WIDTH / 8
) (
    input  logic                    aclk,
    input  logic                    areset,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]              cmd_len,
    input  logic [1:0]              cmd_burst,

    input  logic                    src_valid,
    output logic                    src_ready,
    input  logic [DATA_WIDTH-1:0]   src_data,
    input  logic [STROBE_WIDTH-1:0] src_strb,

    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,

    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [STROBE_WIDTH-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,

    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,

    output logic                    done,
    output logic [1:0]              done_resp
);

    localparam logic [2:0] BEAT_SIZE = 3'($clog2(STROBE_WIDTH));

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } state_t;

    state_t     state;
    logic [7:0] loaded;
    logic       cmd_legal;
    logic       cmd_hs;
    logic       src_hs;
    logic       w_hs;

    assign awsize    = BEAT_SIZE;
    assign cmd_ready = (state == IDLE) && !areset;
    assign cmd_hs    = cmd_valid && cmd_ready;

    // The wvalid&&wlast term stops a wrapped 8-bit count (len 255) from re-opening the source.
    assign src_ready = (state == DATA) && !areset && (loaded <= awlen)
                       && !(wvalid && wlast) && (!wvalid || wready);
    assign src_hs    = src_valid && src_ready;
    assign w_hs      = wvalid && wready;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cmd_legal = 1'b1;
        case (cmd_burst)
            2'b11:   cmd_legal = 1'b0;
            2'b10:   cmd_legal = (cmd_len == 8'd1) || (cmd_len == 8'd3) ||
                                 (cmd_len == 8'd7) || (cmd_len == 8'd15);
            default: cmd_legal = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge aclk) begin
        if (areset) begin
            // NOTE: datapath registers are reset as well, since their reset values are visible.
            state     <= IDLE;
            loaded    <= 8'd0;
            awaddr    <= '0;
            awlen     <= 8'd0;
            awburst   <= 2'b00;
            awvalid   <= 1'b0;
            wdata     <= '0;
            wstrb     <= '0;
            wlast     <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            done      <= 1'b0;
            done_resp <= 2'b00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_hs) begin
                        if (cmd_legal) begin
                            awaddr  <= cmd_addr;
                            awlen   <= cmd_len;
                            awburst <= cmd_burst;
                            awvalid <= 1'b1;
                            state   <= ADDR;
                        end else begin
                            done      <= 1'b1;
                            done_resp <= 2'b10;
                        end
                    end
                end

                ADDR: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        loaded  <= 8'd0;
                        state   <= DATA;
                    end
                end

                DATA: begin
                    if (src_hs) begin
                        wdata  <= src_data;
                        wstrb  <= src_strb;
                        wlast  <= (loaded == awlen);
                        wvalid <= 1'b1;
                        loaded <= loaded + 8'd1;
                    end else if (w_hs) begin
                        wvalid <= 1'b0;
                    end

                    if (w_hs && wlast) begin
                        wvalid <= 1'b0;
                        wlast  <= 1'b0;
                        bready <= 1'b1;
                        state  <= RESP;
                    end
                end

                RESP: begin
                    if (bvalid && bready) begin
                        bready    <= 1'b0;
                        done_resp <= bresp;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi_write_master.md
# axi_write_master

AXI4 write-channel initiator: the master-side counterpart that drives the AW, W and B channels of our AXI write slave. It accepts one burst command at a time from a local command port and takes the beat data from a local valid/ready stream. It issues the address phase, then streams the beats through a registered W stage with `wlast` generated internally. It then collects the write response and reports it on a one-cycle completion pulse.

## Interface
Parameters:
- `ADDR_WIDTH`, 8, address width of `cmd_addr` and `awaddr`.
- `DATA_WIDTH`, 16, data width of `src_data` and `wdata`; must be a multiple of 8.
- `STROBE_WIDTH`, `DATA_WIDTH/8`, byte-strobe width.

Ports:
- `aclk`  in  1  clock; all logic is on the rising edge.
- `areset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  burst command valid.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_addr`  in  ADDR_WIDTH  burst start address.
- `cmd_len`  in  8  beats minus one.
- `cmd_burst`  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- `src_valid` / `src_ready`  in / out  1  beat stream handshake.
- `src_data`  in  DATA_WIDTH  beat data.
- `src_strb`  in  STROBE_WIDTH  beat byte strobes.
- `awaddr`  out  ADDR_WIDTH  AXI write address.
- `awlen`  out  8  AXI write burst length.
- `awsize`  out  3  AXI write beat size.
- `awburst`  out  2  AXI write burst type.
- `awvalid`  out  1  AXI write-address valid.
- `awready`  in  1  AXI write-address ready.
- `wdata`  out  DATA_WIDTH  AXI write data.
- `wstrb`  out  STROBE_WIDTH  AXI write strobes.
- `wlast`  out  1  last beat of the burst.
- `wvalid`  out  1  AXI write-data valid.
- `wready`  in  1  AXI write-data ready.
- `bresp`  in  2  AXI write response.
- `bvalid`  in  1  AXI write-response valid.
- `bready`  out  1  AXI write-response ready.
- `done`  out  1  one-cycle completion pulse.
- `done_resp`  out  2  response reported with `done`.

## Operation
- States:
  - `IDLE`
  - `ADDR`: AW outstanding.
  - `DATA`: beats being sent.
  - `RESP`: waiting for B.
- `cmd_ready` = (state==`IDLE`) && !`areset`.
- `IDLE`:
  - On a command handshake, the command is checked for legality. A command is illegal if `cmd_burst`==11, or if `cmd_burst`==10 and `cmd_len` is not in {1,3,7,15}.
  - Legal command: `awaddr`/`awlen`/`awburst` are registered from the command, `awvalid`<=1, and the state moves to `ADDR`.
  - Illegal command: no AXI traffic is issued, no source beats are consumed, `done`<=1 and `done_resp`<=2'b10 on the next cycle, and the state stays `IDLE`.
- `awsize` is the constant log2(STROBE_WIDTH), which is 1 for the default parameters.
- `ADDR`: `awvalid` and all AW fields are held stable until `awready`. On the handshake, `awvalid`<=0 and the state moves to `DATA`. No W beat is presented before the AW handshake.
- `DATA`:
  - An 8-bit counter `loaded` counts beats taken from the source.
  - `src_ready` = (state==`DATA`) && (`loaded` <= `awlen`) && (!`wvalid` || `wready`).
  - On a source handshake: `wdata`<=`src_data`, `wstrb`<=`src_strb`, `wlast`<=(`loaded`==`awlen`), `wvalid`<=1, and `loaded` increments.
  - If `wvalid && wready` occurs without a new load, `wvalid`<=0.
  - While `wvalid && !wready`, `wdata`, `wstrb` and `wlast` are held stable.
  - On `wvalid && wready && wlast`, the state moves to `RESP` and `wvalid`<=0.
- `RESP`:
  - `bready`<=1 on entry.
  - On `bvalid && bready`: `bready`<=0, `done_resp`<=`bresp`, `done`<=1 for exactly one cycle, and the state returns to `IDLE`.
- `done_resp` holds its value until the next `done`.
- 4 KB-boundary crossing and address alignment are not checked; the command issuer guarantees them.

## Timing
- Reset values:
  - `awvalid`, `wvalid`, `wlast`, `bready`, `done` = 0.
  - `awaddr`, `awlen`, `awburst`, `wdata`, `wstrb`, `done_resp` = 0.
  - `cmd_ready` and `src_ready` = 0 while `areset` is high.
  - State = `IDLE`, `loaded` = 0.
- Reset asserted mid-operation: every output takes its reset value on the next edge and the AXI transaction is abandoned. The slave is reset by the same signal.
- Command handshake at edge N: `awvalid`=1 from N+1.
- AW handshake at edge M: the first `src_ready` is possible in cycle M+1, and the first `wvalid` is at M+2.
- Throughput: one beat per cycle when `src_valid` and `wready` are held high.
- Last W handshake at edge L: `bready`=1 from L+1.
- B handshake at edge K: `done`=1 in cycle K+1, and `cmd_ready`=1 in cycle K+1.
- Minimum command-to-command spacing with zero wait states, len 0: 5 cycles.
- Simultaneous load and drain in `DATA` (`wvalid && wready && src_valid`): the new beat replaces the old one in the same edge, with no bubble.

## Test plan
- INCR, `cmd_addr`=0x10, len 3, `awready`/`wready`/`src_valid` held high, data 0xA000-0xA003, strb 2'b11.
  - Expect `awaddr`=0x10, `awlen`=3, `awburst`=01, `awsize`=1.
  - Expect four contiguous W beats in order, with `wlast` only on 0xA003.
  - `bresp`=00 → `done` pulse with `done_resp`=00.
- `awready` held low for 5 cycles.
  - Expect `awvalid` held and AW fields stable throughout.
  - Expect `wvalid`=0 and `src_ready`=0 until the cycle after the AW handshake.
- Len 3 with `wready` pattern 0,1,0,1,... and `src_valid` gaps.
  - Expect `wdata`/`wstrb` stable whenever `wvalid && !wready`.
  - Expect exactly 4 beats in order, with no extra `src_ready` after the 4th load.
- Len 0, single beat 0x1234.
  - Expect `wlast`=1 on the first beat.
  - `bresp`=2'b10 → `done_resp`=10.
- Illegal commands.
  - `cmd_burst`=11 → no `awvalid` and no `src_ready`; `done`=1 the next cycle with `done_resp`=10.
  - WRAP with len 2 → same response.
  - WRAP with len 3 → normal burst.
- Reset mid-burst.
  - Assert `areset` after the 2nd W beat of a len-3 burst.
  - Expect every output at its reset value at the next edge.
  - After release, a new INCR command completes normally with `loaded` restarted from 0.
